// File: rtl/mem_access_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_ctrl_pkg
// Description : Shared FSM encodings, RV32 load/store funct3 values and
//               extender codes for the memory access controller.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_access_ctrl_pkg;

    localparam logic [1:0] C_ST_IDLE  = 2'd0;
    localparam logic [1:0] C_ST_BEAT0 = 2'd1;
    localparam logic [1:0] C_ST_BEAT1 = 2'd2;
    localparam logic [1:0] C_ST_RESP  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = C_ST_IDLE,
        ST_BEAT0 = C_ST_BEAT0,
        ST_BEAT1 = C_ST_BEAT1,
        ST_RESP  = C_ST_RESP
    } state_t;

    localparam logic [2:0] C_F3_B  = 3'b000;
    localparam logic [2:0] C_F3_H  = 3'b001;
    localparam logic [2:0] C_F3_W  = 3'b010;
    localparam logic [2:0] C_F3_BU = 3'b100;
    localparam logic [2:0] C_F3_HU = 3'b101;

    localparam logic [2:0] C_EXT_NONE = 3'b000;
    localparam logic [2:0] C_EXT_LB   = 3'b001;
    localparam logic [2:0] C_EXT_LH   = 3'b010;
    localparam logic [2:0] C_EXT_LW   = 3'b011;
    localparam logic [2:0] C_EXT_LBU  = 3'b100;
    localparam logic [2:0] C_EXT_LHU  = 3'b101;

    function automatic logic f3_legal(input logic write, input logic [2:0] f3);
        logic ok;
        ok = 1'b0;
        case (f3)
            C_F3_B, C_F3_H, C_F3_W: ok = 1'b1;
            C_F3_BU, C_F3_HU:       ok = !write;
            default:                ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [2:0] ext_code(input logic write, input logic [2:0] f3);
        logic [2:0] code;
        code = C_EXT_NONE;
        if (!write) begin
            case (f3)
                C_F3_B:  code = C_EXT_LB;
                C_F3_H:  code = C_EXT_LH;
                C_F3_W:  code = C_EXT_LW;
                C_F3_BU: code = C_EXT_LBU;
                C_F3_HU: code = C_EXT_LHU;
                default: code = C_EXT_NONE;
            endcase
        end
        return code;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_lane_align.sv
`default_nettype none
// ============================================================================
// Module      : mem_lane_align
// Description : Combinational lane steering for a byte/half/word access that
//               may span two words: byte enables, store shift, load extract.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_lane_align (
    input  logic [1:0]  i_offset,
    input  logic [1:0]  i_size_code,
    input  logic [31:0] i_store_data,
    input  logic [31:0] i_load_lo,
    input  logic [31:0] i_load_hi,
    output logic [3:0]  o_be_lo,
    output logic [3:0]  o_be_hi,
    output logic        o_split,
    output logic [31:0] o_wdata_lo,
    output logic [31:0] o_wdata_hi,
    output logic [31:0] o_load_data
);

    logic [7:0]  w_mask_base;
    logic [7:0]  w_span;
    logic [63:0] w_wshift;
    logic [63:0] w_rshift;
    logic [31:0] w_keep;

    always_comb begin
        case (i_size_code)
            2'b00:   begin w_mask_base = 8'h01; w_keep = 32'h0000_00FF; end
            2'b01:   begin w_mask_base = 8'h03; w_keep = 32'h0000_FFFF; end
            default: begin w_mask_base = 8'h0F; w_keep = 32'hFFFF_FFFF; end
        endcase
        // The 8-lane span covers both words; the upper nibble belongs to the second beat.
        w_span      = w_mask_base << i_offset;
        w_wshift    = {32'h0, i_store_data} << {i_offset, 3'b000};
        w_rshift    = {i_load_hi, i_load_lo} >> {i_offset, 3'b000};
        o_be_lo     = w_span[3:0];
        o_be_hi     = w_span[7:4];
        o_split     = |w_span[7:4];
        o_wdata_lo  = w_wshift[31:0];
        o_wdata_hi  = w_wshift[63:32];
        o_load_data = w_rshift[31:0] & w_keep;
    end

endmodule
`default_nettype wire

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_ctrl
// Description : RV32 load/store to word-memory bridge; splits misaligned
//               accesses into two beats with per-beat ack timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic [2:0]  resp_ext_ctrl,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int C_WAIT_W = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);
    localparam logic [C_WAIT_W-1:0] C_WAIT_LAST = C_WAIT_W'(ACK_TIMEOUT - 1);
    localparam logic [C_WAIT_W-1:0] C_WAIT_ONE  = C_WAIT_W'(1);

    state_t              r_state;
    state_t              w_next;
    logic                r_write;
    logic [1:0]          r_size;
    logic [31:0]         r_addr;
    logic [31:0]         r_wdata;
    logic                r_err;
    logic [2:0]          r_ext;
    logic [31:0]         r_beat0;
    logic [31:0]         r_beat1;
    logic [C_WAIT_W-1:0] r_wait;

    logic        w_accept;
    logic        w_legal;
    logic        w_in_beat;
    logic        w_timeout;
    logic [31:0] w_word0;
    logic [31:0] w_word1;
    logic [3:0]  w_be_lo;
    logic [3:0]  w_be_hi;
    logic        w_split;
    logic [31:0] w_wdata_lo;
    logic [31:0] w_wdata_hi;
    logic [31:0] w_load;

    assign w_accept  = req_valid && (r_state == ST_IDLE);
    assign w_legal   = f3_legal(req_write, req_funct3);
    assign w_in_beat = (r_state == ST_BEAT0) || (r_state == ST_BEAT1);
    assign w_timeout = (r_wait == C_WAIT_LAST);
    assign w_word0   = {r_addr[31:2], 2'b00};
    assign w_word1   = w_word0 + 32'd4;

    mem_lane_align u_lane_align (
        .i_offset     (r_addr[1:0]),
        .i_size_code  (r_size),
        .i_store_data (r_wdata),
        .i_load_lo    (r_beat0),
        .i_load_hi    (r_beat1),
        .o_be_lo      (w_be_lo),
        .o_be_hi      (w_be_hi),
        .o_split      (w_split),
        .o_wdata_lo   (w_wdata_lo),
        .o_wdata_hi   (w_wdata_hi),
        .o_load_data  (w_load)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) w_next = w_legal ? ST_BEAT0 : ST_RESP;
            end
            ST_BEAT0: begin
                if (mem_ack)        w_next = w_split ? ST_BEAT1 : ST_RESP;
                else if (w_timeout) w_next = ST_RESP;
            end
            ST_BEAT1: begin
                if (mem_ack || w_timeout) w_next = ST_RESP;
            end
            ST_RESP: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_write <= 1'b0;
            r_size  <= 2'b00;
            r_addr  <= 32'h0;
            r_wdata <= 32'h0;
            r_err   <= 1'b0;
            r_ext   <= C_EXT_NONE;
            r_beat0 <= 32'h0;
            r_beat1 <= 32'h0;
            r_wait  <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_write <= req_write;
                r_size  <= req_funct3[1:0];
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_err   <= !w_legal;
                r_ext   <= w_legal ? ext_code(req_write, req_funct3) : C_EXT_NONE;
                r_beat0 <= 32'h0;
                r_beat1 <= 32'h0;
                r_wait  <= '0;
            end
            // The counter restarts on every ack so the second beat gets a full budget.
            if (w_in_beat) begin
                if (mem_ack) begin
                    r_wait <= '0;
                    if (r_state == ST_BEAT0) r_beat0 <= mem_rdata;
                    else                     r_beat1 <= mem_rdata;
                end else if (w_timeout) begin
                    r_wait <= '0;
                    r_err  <= 1'b1;
                end else begin
                    r_wait <= r_wait + C_WAIT_ONE;
                end
            end
        end
    end

    assign req_ready     = (r_state == ST_IDLE);
    assign mem_req       = w_in_beat;
    assign mem_we        = w_in_beat && r_write;
    assign mem_addr      = (r_state == ST_BEAT1) ? w_word1 :
                           (r_state == ST_BEAT0) ? w_word0 : 32'h0;
    assign mem_be        = (r_state == ST_BEAT1) ? w_be_hi :
                           (r_state == ST_BEAT0) ? w_be_lo : 4'b0000;
    assign mem_wdata     = !mem_we                ? 32'h0      :
                           (r_state == ST_BEAT1) ? w_wdata_hi : w_wdata_lo;
    assign resp_valid    = (r_state == ST_RESP);
    assign resp_err      = resp_valid && r_err;
    assign resp_ext_ctrl = resp_valid ? r_ext : C_EXT_NONE;
    assign resp_rdata    = (resp_valid && !r_write && !r_err) ? w_load : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_ctrl
// Description : Directed self-checking bench with a byte-level access model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mem_access_ctrl;

    localparam int ACK_TIMEOUT = 255;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic [2:0]  resp_ext_ctrl;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    always #5 clk = ~clk;

    mem_access_ctrl #(.ACK_TIMEOUT(ACK_TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
        .resp_ext_ctrl(resp_ext_ctrl),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        chk_en = 1'b0;
    logic        e_req_ready, e_mem_req, e_mem_we, e_resp_valid, e_resp_err;
    logic [31:0] e_mem_addr, e_mem_wdata, e_resp_rdata;
    logic [3:0]  e_mem_be;
    logic [2:0]  e_ext;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @cyc %0d: got %h, want %h", name, cyc, act, exp);
        end
    endtask

    // Per-cycle comparison of every output against the model's expectation.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("req_ready",  {31'h0, req_ready},  {31'h0, e_req_ready});
            chk("mem_req",    {31'h0, mem_req},    {31'h0, e_mem_req});
            chk("mem_we",     {31'h0, mem_we},     {31'h0, e_mem_we});
            chk("mem_addr",   mem_addr,            e_mem_addr);
            chk("mem_be",     {28'h0, mem_be},     {28'h0, e_mem_be});
            chk("mem_wdata",  mem_wdata,           e_mem_wdata);
            chk("resp_valid", {31'h0, resp_valid}, {31'h0, e_resp_valid});
            chk("resp_err",   {31'h0, resp_err},   {31'h0, e_resp_err});
            chk("resp_rdata", resp_rdata,          e_resp_rdata);
            chk("resp_ext",   {29'h0, resp_ext_ctrl}, {29'h0, e_ext});
        end
    end

    // Observation log for the hand-computed literal checks.
    logic [31:0] q_addr[$];
    logic [3:0]  q_be[$];
    logic [31:0] q_wd[$];
    int          resp_cnt = 0;
    int          mreq_cnt = 0;
    int          resp_cyc = 0;
    int          acc_cyc  = 0;
    logic [31:0] last_rdata;
    logic [2:0]  last_ext;
    logic        last_err;

    always @(negedge clk) begin
        if (resp_valid) begin
            resp_cnt++;
            resp_cyc   = cyc;
            last_rdata = resp_rdata;
            last_ext   = resp_ext_ctrl;
            last_err   = resp_err;
        end
        if (mem_req) mreq_cnt++;
        if (mem_req && mem_ack) begin
            q_addr.push_back(mem_addr);
            q_be.push_back(mem_be);
            q_wd.push_back(mem_wdata);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_idle();
        e_req_ready = 1'b1; e_mem_req = 1'b0; e_mem_we = 1'b0; e_mem_addr = 32'h0;
        e_mem_be = 4'h0; e_mem_wdata = 32'h0; e_resp_valid = 1'b0; e_resp_err = 1'b0;
        e_resp_rdata = 32'h0; e_ext = 3'b000;
    endtask

    task automatic exp_beat(input logic wr, input logic [31:0] a, input logic [3:0] be,
                            input logic [31:0] wd);
        exp_idle();
        e_req_ready = 1'b0; e_mem_req = 1'b1; e_mem_we = wr;
        e_mem_addr = a; e_mem_be = be; e_mem_wdata = wr ? wd : 32'h0;
    endtask

    task automatic clear_log();
        q_addr.delete(); q_be.delete(); q_wd.delete();
        resp_cnt = 0; mreq_cnt = 0;
    endtask

    // Model: lays the access out over an 8-byte window spanning two words.
    // wait<0 means the beat never acks.
    task automatic run_txn(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rd0,
                           input logic [31:0] rd1, input int wait0, input int wait1,
                           input logic noise);
        logic [7:0]  span[8];
        logic [7:0]  rb[8];
        logic [31:0] wd[2];
        logic [3:0]  be[2];
        logic [31:0] wa[2];
        logic [31:0] ld;
        logic [2:0]  ext;
        logic        legal, tmo, done;
        int          o, n, nb, w, c;
        legal = wr ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        n  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        o  = int'(addr[1:0]);
        nb = (o + n > 4) ? 2 : 1;
        for (int i = 0; i < 8; i++) begin
            span[i] = 8'h00;
            rb[i]   = (i < 4) ? rd0[8*i +: 8] : rd1[8*(i-4) +: 8];
        end
        for (int i = 0; i < 4; i++) span[o+i] = wdata[8*i +: 8];
        be[0] = 4'h0; be[1] = 4'h0;
        for (int i = o; i < o + n; i++) be[i/4][i%4] = 1'b1;
        wd[0] = {span[3], span[2], span[1], span[0]};
        wd[1] = {span[7], span[6], span[5], span[4]};
        wa[0] = {addr[31:2], 2'b00};
        wa[1] = wa[0] + 32'd4;
        ld = 32'h0;
        for (int j = 0; j < n; j++) ld[8*j +: 8] = rb[o+j];
        case (f3)
            3'd0: ext = 3'b001;
            3'd1: ext = 3'b010;
            3'd2: ext = 3'b011;
            3'd4: ext = 3'b100;
            3'd5: ext = 3'b101;
            default: ext = 3'b000;
        endcase
        if (wr || !legal) ext = 3'b000;

        clear_log();
        req_valid = 1'b1; req_write = wr; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        mem_ack = noise; mem_rdata = 32'hA5A5_A5A5;
        exp_idle();
        acc_cyc = cyc;
        step();
        req_valid = 1'b0; req_addr = 32'hFFFF_FFFF; req_wdata = 32'hFFFF_FFFF;
        tmo = 1'b0;
        if (legal) begin
            for (int b = 0; b < nb && !tmo; b++) begin
                w = (b == 0) ? wait0 : wait1;
                c = 0;
                done = 1'b0;
                while (!done) begin
                    exp_beat(wr, wa[b], be[b], wd[b]);
                    mem_ack   = (c == w);
                    mem_rdata = (c == w) ? ((b == 0) ? rd0 : rd1) : (32'hBAD0_0000 ^ c);
                    step();
                    if (c == w) done = 1'b1;
                    else begin
                        c++;
                        if (c == ACK_TIMEOUT) begin tmo = 1'b1; done = 1'b1; end
                    end
                end
            end
        end
        exp_idle();
        e_req_ready = 1'b0; e_resp_valid = 1'b1; e_resp_err = !legal || tmo; e_ext = ext;
        e_resp_rdata = (!wr && legal && !tmo) ? ld : 32'h0;
        mem_ack = noise; mem_rdata = 32'h5A5A_5A5A;
        step();
        mem_ack = 1'b0;
        exp_idle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'b000;
        req_addr = 32'h0; req_wdata = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
        exp_idle();
        step();
        chk_en = 1'b1;
        step();
        reset = 1'b0;
        step();

        // lw aligned, zero-wait ack
        run_txn(1'b0, 3'b010, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 32'h0, 0, 0, 1'b0);
        chk("lw_be",      {28'h0, q_be[0]}, 32'h0000_000F);
        chk("lw_rdata",   last_rdata, 32'hDEAD_BEEF);
        chk("lw_ext",     {29'h0, last_ext}, 32'd3);
        chk("lw_latency", resp_cyc - acc_cyc, 32'd2);

        // sb at byte 3
        run_txn(1'b1, 3'b000, 32'h0000_0203, 32'h0000_00AB, 32'h0, 32'h0, 0, 0, 1'b0);
        chk("sb_addr",  q_addr[0], 32'h0000_0200);
        chk("sb_be",    {28'h0, q_be[0]}, 32'h0000_0008);
        chk("sb_lane",  {24'h0, q_wd[0][31:24]}, 32'h0000_00AB);
        chk("sb_err",   {31'h0, last_err}, 32'd0);

        // lhu straddling a word boundary, ack noise outside beats
        run_txn(1'b0, 3'b101, 32'h0000_0103, 32'h0, 32'h1122_3344, 32'h5566_7788, 0, 0, 1'b1);
        chk("lhu_beats", q_addr.size(), 32'd2);
        chk("lhu_addr1", q_addr[1], 32'h0000_0104);
        chk("lhu_be0",   {28'h0, q_be[0]}, 32'h0000_0008);
        chk("lhu_be1",   {28'h0, q_be[1]}, 32'h0000_0001);
        chk("lhu_rdata", last_rdata, 32'h0000_8811);
        chk("lhu_ext",   {29'h0, last_ext}, 32'd5);

        // sw wrapping past the top of the address space
        run_txn(1'b1, 3'b010, 32'hFFFF_FFFE, 32'h0102_0304, 32'h0, 32'h0, 1, 2, 1'b0);
        chk("sw_addr0", q_addr[0], 32'hFFFF_FFFC);
        chk("sw_addr1", q_addr[1], 32'h0000_0000);
        chk("sw_be0",   {28'h0, q_be[0]}, 32'h0000_000C);
        chk("sw_be1",   {28'h0, q_be[1]}, 32'h0000_0003);
        chk("sw_wd0",   q_wd[0], 32'h0304_0000);
        chk("sw_wd1",   q_wd[1], 32'h0000_0102);

        // illegal load funct3
        run_txn(1'b0, 3'b011, 32'h0000_0400, 32'h0, 32'h0, 32'h0, 0, 0, 1'b1);
        chk("ill_mreq",    mreq_cnt, 32'd0);
        chk("ill_err",     {31'h0, last_err}, 32'd1);
        chk("ill_latency", resp_cyc - acc_cyc, 32'd1);

        // unsigned-only funct3 rejected for a store
        run_txn(1'b1, 3'b100, 32'h0000_0408, 32'h1234_5678, 32'h0, 32'h0, 0, 0, 1'b0);

        // assorted legal accesses with wait states
        run_txn(1'b0, 3'b000, 32'h0000_0101, 32'h0, 32'h8899_AABB, 32'h0, 2, 0, 1'b0);
        run_txn(1'b0, 3'b001, 32'h0000_0102, 32'h0, 32'hCAFE_F00D, 32'h0, 0, 0, 1'b1);
        run_txn(1'b0, 3'b100, 32'h0000_0503, 32'h0, 32'h7766_5544, 32'h0, 1, 0, 1'b0);
        run_txn(1'b0, 3'b001, 32'h0000_0603, 32'h0, 32'hAABB_CCDD, 32'h1122_3344, 1, 3, 1'b1);
        run_txn(1'b0, 3'b010, 32'h0000_0701, 32'h0, 32'h0403_0201, 32'h0807_0605, 0, 1, 1'b0);
        run_txn(1'b1, 3'b001, 32'h0000_0803, 32'hFFFF_BEEF, 32'h0, 32'h0, 0, 0, 1'b0);
        run_txn(1'b1, 3'b001, 32'h0000_0902, 32'h0000_1234, 32'h0, 32'h0, 3, 0, 1'b1);

        // ack never arrives
        run_txn(1'b0, 3'b010, 32'h0000_0300, 32'h0, 32'h0, 32'h0, -1, 0, 1'b0);
        chk("tmo_err",     {31'h0, last_err}, 32'd1);
        chk("tmo_rdata",   last_rdata, 32'h0);
        chk("tmo_latency", resp_cyc - acc_cyc, 32'd256);

        // reset while the second beat is waiting for ack
        clear_log();
        req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b101; req_addr = 32'h0000_0103;
        exp_idle();
        step();
        req_valid = 1'b0;
        exp_beat(1'b0, 32'h0000_0100, 4'b1000, 32'h0);
        mem_ack = 1'b1; mem_rdata = 32'h1122_3344;
        step();
        mem_ack = 1'b0;
        exp_beat(1'b0, 32'h0000_0104, 4'b0001, 32'h0);
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        exp_idle();
        for (int k = 0; k < 4; k++) step();
        chk("rst_no_resp", resp_cnt, 32'd0);
        chk("rst_ready",   {31'h0, req_ready}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
